// File: rtl/fir_pkg.sv
// Shared definitions for the ECG filter chain: width helpers, FSM state
// encoding and the default low-pass half coefficient set.
package fir_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

    function automatic int preadd_w(input int data_w);
        return data_w + 1;
    endfunction

    function automatic int prod_w(input int data_w, input int coef_w);
        return data_w + 1 + coef_w;
    endfunction

    // Wide enough that TAPS/2 worst-case products can never overflow.
    function automatic int acc_w(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + 1 + clog2(taps / 2);
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } fir_state_t;

    // Default ECG low-pass, taps h[0..63]; h[127-k] mirrors h[k].
    localparam int DEF_HALF_TAPS = 64;
    localparam logic signed [15:0] DEF_COEF [DEF_HALF_TAPS] = '{
          0,  -1,  -2,  -3,  -4,  -6,  -8, -10, -12, -14, -15, -16, -16, -15, -12,  -8,
         -2,   6,  16,  28,  42,  58,  76,  96, 118, 141, 166, 192, 219, 247, 276, 305,
        335, 365, 395, 425, 455, 484, 512, 539, 565, 589, 612, 633, 652, 669, 684, 697,
        708, 717, 724, 729, 732, 734, 735, 736, 737, 738, 739, 740, 741, 742, 743, 744
    };

endpackage

// File: rtl/fir_round_sat.sv
// Combinational round-half-up, arithmetic right shift and saturation of a
// wide accumulator down to OUT_W bits. Shared by the filter-chain blocks.
module fir_round_sat #(
    parameter int ACC_W = 39,
    parameter int OUT_W = 16,
    parameter int SHIFT = 15
) (
    input  logic signed [ACC_W-1:0] i_acc,
    output logic signed [OUT_W-1:0] o_data,
    output logic                    o_sat
);
    // One guard bit for the rounding add, and room to hold the output limits.
    localparam int CMP_W = (ACC_W > OUT_W) ? ACC_W + 1 : OUT_W + 1;
    localparam logic signed [CMP_W-1:0] RND_K = CMP_W'(1) <<< (SHIFT - 1);
    localparam logic signed [CMP_W-1:0] MAX_V =
        $signed({{(CMP_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
    localparam logic signed [CMP_W-1:0] MIN_V =
        $signed({{(CMP_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}});

    function automatic logic signed [CMP_W-1:0] round_shift(input logic signed [ACC_W-1:0] acc);
        logic signed [CMP_W-1:0] t;
        t = CMP_W'(acc) + RND_K;
        return t >>> SHIFT;
    endfunction

    // Returns {clipped, value}.
    function automatic logic [OUT_W:0] saturate(input logic signed [CMP_W-1:0] v);
        if (v > MAX_V) return {1'b1, MAX_V[OUT_W-1:0]};
        if (v < MIN_V) return {1'b1, MIN_V[OUT_W-1:0]};
        return {1'b0, v[OUT_W-1:0]};
    endfunction

    logic signed [CMP_W-1:0] w_rnd;
    logic        [OUT_W:0]   w_res;

    assign w_rnd  = round_shift(i_acc);
    assign w_res  = saturate(w_rnd);
    assign o_sat  = w_res[OUT_W];
    assign o_data = w_res[OUT_W-1:0];

endmodule

// File: rtl/fir_sym_mac.sv
// Time-multiplexed symmetric FIR: one pre-adder and one MAC fold each tap
// pair, giving TAPS/2 MAC cycles per sample, then round/saturate to OUT_W.
module fir_sym_mac
    import fir_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 128,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [DATA_W-1:0]      in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [OUT_W-1:0]       out_data,
    output logic                          out_sat,
    input  logic                          coef_we,
    input  logic [clog2(TAPS/2)-1:0]      coef_addr,
    input  logic signed [COEF_W-1:0]      coef_wdata,
    output logic                          busy
);
    localparam int HALF  = TAPS / 2;
    localparam int AW    = clog2(TAPS);
    localparam int KW    = clog2(HALF);
    localparam int PA_W  = preadd_w(DATA_W);
    localparam int PR_W  = prod_w(DATA_W, COEF_W);
    localparam int ACC_W = acc_w(DATA_W, COEF_W, TAPS);
    localparam logic [KW-1:0] K_LAST = KW'(HALF - 1);
    localparam logic [AW-1:0] P_LAST = AW'(TAPS - 1);

    fir_state_t               r_state, w_state_nx;
    logic signed [DATA_W-1:0] r_hist [TAPS];
    logic signed [COEF_W-1:0] r_coef [HALF];
    logic [AW-1:0]            r_wr_ptr;
    logic [AW-1:0]            r_newest;
    logic [KW-1:0]            r_k;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [OUT_W-1:0]  r_out_data;
    logic                     r_out_sat;

    logic                     w_accept;
    logic signed [DATA_W-1:0] w_x_near;
    logic signed [DATA_W-1:0] w_x_far;
    logic signed [PA_W-1:0]   w_pre;
    logic signed [PR_W-1:0]   w_prod;
    logic signed [OUT_W-1:0]  w_rnd_data;
    logic                     w_rnd_sat;

    // Circular history: sample of age j lives at (newest - j) mod TAPS.
    function automatic logic [AW-1:0] age_addr(input logic [AW-1:0] newest, input int age);
        int a;
        a = int'(newest) + TAPS - age;
        if (a >= TAPS) a = a - TAPS;
        return a[AW-1:0];
    endfunction

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_x_near = r_hist[age_addr(r_newest, int'(r_k))];
    assign w_x_far  = r_hist[age_addr(r_newest, TAPS - 1 - int'(r_k))];
    assign w_pre    = PA_W'(w_x_near) + PA_W'(w_x_far);
    assign w_prod   = PR_W'(w_pre) * PR_W'(r_coef[r_k]);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nx;
    end

    // Next-state: one accept, HALF MAC cycles, one round cycle, hold until taken
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (in_valid)       w_state_nx = MAC;
            MAC:     if (r_k == K_LAST)  w_state_nx = ROUND;
            ROUND:                       w_state_nx = OUT;
            OUT:     if (out_ready)      w_state_nx = IDLE;
            default:                     w_state_nx = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            OUT:     out_valid = 1'b1;
            default: ;
        endcase
    end

    // Sample ring: write the accepted sample and remember where x[n] sits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) r_hist[i] <= '0;
            r_wr_ptr <= '0;
            r_newest <= '0;
        end else if (w_accept) begin
            r_hist[r_wr_ptr] <= in_data;
            r_newest         <= r_wr_ptr;
            r_wr_ptr         <= (r_wr_ptr == P_LAST) ? '0 : r_wr_ptr + 1'b1;
        end
    end

    // Coefficient RAM: writable only while idle, so a running sum never mixes sets
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < HALF; i++) r_coef[i] <= '0;
        end else if (coef_we && (r_state == IDLE) && (int'(coef_addr) < HALF)) begin
            r_coef[coef_addr] <= coef_wdata;
        end
    end

    // Accumulator and tap-pair index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_k   <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_acc <= '0;
                    r_k   <= '0;
                end
                MAC: begin
                    r_acc <= r_acc + ACC_W'(w_prod);
                    r_k   <= r_k + 1'b1;
                end
                default: ;
            endcase
        end
    end

    fir_round_sat #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_round (
        .i_acc  (r_acc),
        .o_data (w_rnd_data),
        .o_sat  (w_rnd_sat)
    );

    // Result register: captured in ROUND, held through OUT until taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data <= '0;
            r_out_sat  <= 1'b0;
        end else if (r_state == ROUND) begin
            r_out_data <= w_rnd_data;
            r_out_sat  <= w_rnd_sat;
        end
    end

    assign out_data = r_out_data;
    assign out_sat  = r_out_sat;

endmodule

// File: tb/tb_fir_sym_mac.sv
// Directed and reference-model bench for fir_sym_mac (default and TAPS=8/OUT_W=24).
module tb_fir_sym_mac;
    import fir_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic               in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_sat, busy;
    logic signed [15:0] in_data = '0, out_data, coef_wdata = '0;
    logic               coef_we = 1'b0;
    logic [5:0]         coef_addr = '0;

    // TAPS=8, OUT_W=24 instance
    logic               in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1, out_sat8, busy8;
    logic signed [15:0] in_data8 = '0, coef_wdata8 = '0;
    logic signed [23:0] out_data8;
    logic               coef_we8 = 1'b0;
    logic [1:0]         coef_addr8 = '0;

    fir_sym_mac u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .busy(busy)
    );

    fir_sym_mac #(.TAPS(8), .OUT_W(24)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8), .out_sat(out_sat8),
        .coef_we(coef_we8), .coef_addr(coef_addr8), .coef_wdata(coef_wdata8), .busy(busy8)
    );

    typedef struct {
        logic signed [15:0] din;
        logic signed [15:0] exp_q;
        logic               exp_sat;
    } vec_t;

    vec_t               vecs [256];
    int                 n_chk = 0, n_err = 0;
    longint             m_hist [128];
    longint             m_hist8 [8];
    logic signed [15:0] c8 [4];

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint ref_round(input longint acc, input int shift, input int out_w,
                                         output bit sat);
        longint r, mx, mn;
        r   = (acc + (longint'(1) <<< (shift - 1))) >>> shift;
        mx  = (longint'(1) <<< (out_w - 1)) - 1;
        mn  = -mx - 1;
        sat = 1'b0;
        if (r > mx) begin r = mx; sat = 1'b1; end
        if (r < mn) begin r = mn; sat = 1'b1; end
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b1;
        in_valid8 = 1'b0; coef_we8 = 1'b0; out_ready8 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic write_coef(input int addr, input logic signed [15:0] val);
        coef_we = 1'b1; coef_addr = 6'(addr); coef_wdata = val;
        @(posedge clk); #1;
        coef_we = 1'b0;
    endtask

    task automatic write_coef8(input int addr, input logic signed [15:0] val);
        coef_we8 = 1'b1; coef_addr8 = 2'(addr); coef_wdata8 = val;
        @(posedge clk); #1;
        coef_we8 = 1'b0;
    endtask

    // Offer one sample, wait for its result, take it with out_ready high.
    task automatic send(input logic signed [15:0] d, output logic signed [15:0] q,
                        output logic s, output bit ok);
        int n;
        ok = 1'b1;
        in_data = d; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 300) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 300) begin @(posedge clk); #1; n++; end
        if (!out_valid) ok = 1'b0;
        q = out_data; s = out_sat;
        @(posedge clk); #1;
    endtask

    task automatic send8(input logic signed [15:0] d, output logic signed [23:0] q,
                         output logic s, output bit ok);
        int n;
        ok = 1'b1;
        in_data8 = d; in_valid8 = 1'b1;
        n = 0;
        while (!in_ready8 && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        n = 0;
        while (!out_valid8 && n < 50) begin @(posedge clk); #1; n++; end
        if (!out_valid8) ok = 1'b0;
        q = out_data8; s = out_sat8;
        @(posedge clk); #1;
    endtask

    task automatic wait_out(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 300) begin @(posedge clk); #1; n++; end
        if (!out_valid) check({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic signed [15:0] q, d, first_q;
        logic signed [23:0] q8;
        logic               s, first_s;
        bit                 ok, seen, es;
        int                 lat, wp, idx;
        longint             acc, ev;

        // Impulse table: 1000 then zeros; echo at output 127; 128 more zeros after wrap.
        for (int i = 0; i < 256; i++) vecs[i] = '{din: 16'sd0, exp_q: 16'sd0, exp_sat: 1'b0};
        vecs[0].din   = 16'sd1000;
        vecs[0].exp_q = 16'sd500;
        vecs[127].exp_q = 16'sd500;

        // 1. Reset state and abort
        do_reset();
        for (int c = 0; c < 20; c++) begin
            check("rst_ctrl{rdy,vld,busy}", {in_ready, out_valid, busy}, 3'b100);
            check("rst_data", out_data, 0);
            @(posedge clk); #1;
        end
        write_coef(0, 16'sd16384);
        in_data = 16'sd1000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 check("mid_mac_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        @(posedge clk); #1 rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("abort_no_out_valid", seen, 0);

        // 2. Impulse, symmetry and pointer wrap
        do_reset();
        write_coef(0, 16'sd16384);
        for (int i = 0; i < 256; i++) begin
            send(vecs[i].din, q, s, ok);
            if (!ok) check($sformatf("impulse[%0d]_timeout", i), 0, 1);
            else begin
                check($sformatf("impulse[%0d]_data", i), q, vecs[i].exp_q);
                check($sformatf("impulse[%0d]_sat", i), s, vecs[i].exp_sat);
            end
        end

        // 3. Latency and back-pressure with a held in_valid
        do_reset();
        write_coef(0, 16'sd16384);
        out_ready = 1'b0; in_data = 16'sd1000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_data = 16'sd2000;
        lat = 0;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        check("latency", lat, 65);
        for (int c = 0; c < 10; c++) begin
            check("bp_data", out_data, 500);
            check("bp_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_take", in_ready, 1);
        check("busy_after_take", busy, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out("held_sample");
        check("held_sample_data", out_data, 1000);
        @(posedge clk); #1;

        // 4. Saturation
        do_reset();
        for (int k = 0; k < 64; k++) write_coef(k, 16'sd32767);
        first_q = '0; first_s = 1'b0;
        for (int i = 0; i < 128; i++) begin
            send(16'sd32767, q, s, ok);
            if (!ok) check("sat_pos_timeout", 0, 1);
            if (i == 0) begin first_q = q; first_s = s; end
        end
        check("first_pos_data", first_q, 32766);
        check("first_pos_sat", first_s, 0);
        check("sat_pos_data", q, 32767);
        check("sat_pos_sat", s, 1);
        for (int i = 0; i < 128; i++) begin
            send(16'sh8000, q, s, ok);
            if (!ok) check("sat_neg_timeout", 0, 1);
        end
        check("sat_neg_data", q, -32768);
        check("sat_neg_sat", s, 1);
        do_reset();
        write_coef(0, 16'sd16384);
        send(16'sd100, q, s, ok);
        check("small_data", q, 50);
        check("small_sat", s, 0);
        send(-16'sd1000, q, s, ok);
        check("neg_round_data", q, -500);
        check("neg_round_sat", s, 0);

        // 5. Coefficient write on accept edge, and while busy
        do_reset();
        coef_we = 1'b1; coef_addr = 6'd0; coef_wdata = 16'sd16384;
        in_data = 16'sd1000; in_valid = 1'b1;
        @(posedge clk); #1;
        coef_we = 1'b0; in_valid = 1'b0;
        wait_out("same_cycle_coef");
        check("same_cycle_coef", out_data, 500);
        @(posedge clk); #1;
        in_data = 16'sd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 coef_we = 1'b1; coef_addr = 6'd0; coef_wdata = 16'sd0;
        @(posedge clk); #1 coef_we = 1'b0;
        wait_out("busy_write");
        check("busy_write_zero_sample", out_data, 0);
        @(posedge clk); #1;
        send(16'sd1000, q, s, ok);
        check("busy_write_ignored", q, 500);

        // 6a. Random regression, default coefficients, TAPS=128
        do_reset();
        for (int k = 0; k < 64; k++) write_coef(k, DEF_COEF[k]);
        for (int j = 0; j < 128; j++) m_hist[j] = 0;
        wp = 0;
        for (int i = 0; i < 250; i++) begin
            d = 16'($urandom);
            if (i % 40 == 7)  d = 16'sh7fff;
            if (i % 40 == 23) d = 16'sh8000;
            m_hist[wp] = longint'(d);
            acc = 0;
            for (int j = 0; j < 128; j++) begin
                idx = (wp - j + 128) % 128;
                acc += m_hist[idx] * longint'((j < 64) ? DEF_COEF[j] : DEF_COEF[127 - j]);
            end
            ev = ref_round(acc, 15, 16, es);
            wp = (wp + 1) % 128;
            send(d, q, s, ok);
            if (!ok) check($sformatf("rand128[%0d]_timeout", i), 0, 1);
            else begin
                check($sformatf("rand128[%0d]_data", i), q, ev);
                check($sformatf("rand128[%0d]_sat", i), s, es);
            end
        end

        // 6b. Random regression, TAPS=8, OUT_W=24, random coefficients
        do_reset();
        for (int k = 0; k < 4; k++) begin
            c8[k] = 16'($urandom);
            write_coef8(k, c8[k]);
        end
        for (int j = 0; j < 8; j++) m_hist8[j] = 0;
        wp = 0;
        for (int i = 0; i < 2000; i++) begin
            d = 16'($urandom);
            if (i % 50 == 11) d = 16'sh7fff;
            if (i % 50 == 31) d = 16'sh8000;
            m_hist8[wp] = longint'(d);
            acc = 0;
            for (int j = 0; j < 8; j++) begin
                idx = (wp - j + 8) % 8;
                acc += m_hist8[idx] * longint'((j < 4) ? c8[j] : c8[7 - j]);
            end
            ev = ref_round(acc, 15, 24, es);
            wp = (wp + 1) % 8;
            send8(d, q8, s, ok);
            if (!ok) check($sformatf("rand8[%0d]_timeout", i), 0, 1);
            else begin
                check($sformatf("rand8[%0d]_data", i), q8, ev);
                check($sformatf("rand8[%0d]_sat", i), s, es);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
